// File: rtl/gate_exerciser_if.sv
// Gate exerciser bus: the start/result handshake plus the A/B/Y wires
// that connect to the gate under test. The exerciser uses the master
// modport; the environment (controller and gate under test) uses slave.
interface gate_exerciser_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             y_in;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;

  modport master (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_exerciser.sv
// Gate exerciser: sweeps {A,B} through 00..11 for ROUNDS passes, holds
// each combination SETTLE_CYCLES cycles, samples Y once, and checks it
// against the TRUTH table. Reports pass, a saturating error count and a
// per-combination failure mask. Every output comes straight from a flop.
module gate_exerciser #(
  parameter int       SETTLE_CYCLES = 2,
  parameter logic [3:0] TRUTH       = 4'b1000,
  parameter int       ROUNDS        = 1,
  parameter int       ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  gate_exerciser_if.master bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_t;

  state_t           state_q;
  logic [1:0]       combo_q;
  logic [RW-1:0]    round_q;
  logic [CW-1:0]    settle_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] errCount_q;
  logic [3:0]       failVec_q;

  logic             mismatch;
  logic             lastSample;
  logic [ERR_W-1:0] errCount_d;
  logic [3:0]       failVec_d;

  // Result update for the sample taken this cycle (only committed in SAMPLE).
  always_comb begin
    mismatch   = (bus.y_in != TRUTH[combo_q]);
    lastSample = (combo_q == 2'd3) && (round_q == RW'(ROUNDS - 1));
    errCount_d = errCount_q;
    failVec_d  = failVec_q;
    if (mismatch) begin
      if (errCount_q != {ERR_W{1'b1}}) begin
        errCount_d = errCount_q + ERR_W'(1);
      end
      failVec_d = failVec_q | (4'b0001 << combo_q);
    end
  end

  // Sweep controller: accepts start in IDLE, then settles and samples each combination in turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      combo_q    <= 2'd0;
      round_q    <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      errCount_q <= '0;
      failVec_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= SETTLE;
            busy_q     <= 1'b1;
            combo_q    <= 2'd0;
            round_q    <= '0;
            settle_q   <= '0;
            errCount_q <= '0;
            failVec_q  <= 4'd0;
            pass_q     <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_q == CW'(SETTLE_CYCLES - 1)) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q + CW'(1);
          end
        end
        SAMPLE: begin
          errCount_q <= errCount_d;
          failVec_q  <= failVec_d;
          settle_q   <= '0;
          if (lastSample) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            combo_q <= 2'd0;
            pass_q  <= (errCount_d == '0);
          end else begin
            state_q <= SETTLE;
            combo_q <= combo_q + 2'd1;
            if (combo_q == 2'd3) begin
              round_q <= round_q + RW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_out     = combo_q[1];
  assign bus.b_out     = combo_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = errCount_q;
  assign bus.fail_vec  = failVec_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Self-checking bench for gate_exerciser. Three instances cover the
// parameter sets of interest; each gate under test is a 4-entry lookup
// table driven from the exerciser's own A/B. Expected results come from
// a run-level model: mismatches = popcount(TRUTH ^ table) * ROUNDS.
module tb_gate_exerciser;

  logic clock;
  logic reset;

  logic       startSig  [3];
  logic [3:0] gateTable [3];

  logic [1:0] abObs    [3];
  logic       busyObs  [3];
  logic       doneObs  [3];
  logic       passObs  [3];
  logic [7:0] errObs   [3];
  logic [3:0] failObs  [3];

  int checkCount = 0;
  int failCount  = 0;

  gate_exerciser_if #(.ERR_W(8)) if0 ();
  gate_exerciser_if #(.ERR_W(8)) if1 ();
  gate_exerciser_if #(.ERR_W(8)) if2 ();

  // Default instance: AND truth table, settle 2, one round.
  gate_exerciser #(.SETTLE_CYCLES(2), .TRUTH(4'b1000), .ROUNDS(1), .ERR_W(8))
    dut0 (.clk(clock), .rst(reset), .bus(if0.master));

  // Long run instance for error-count saturation.
  gate_exerciser #(.SETTLE_CYCLES(2), .TRUTH(4'b1000), .ROUNDS(100), .ERR_W(8))
    dut1 (.clk(clock), .rst(reset), .bus(if1.master));

  // XOR instance with minimum settle and two rounds.
  gate_exerciser #(.SETTLE_CYCLES(1), .TRUTH(4'b0110), .ROUNDS(2), .ERR_W(8))
    dut2 (.clk(clock), .rst(reset), .bus(if2.master));

  assign if0.start = startSig[0];
  assign if1.start = startSig[1];
  assign if2.start = startSig[2];

  assign if0.y_in = gateTable[0][{if0.a_out, if0.b_out}];
  assign if1.y_in = gateTable[1][{if1.a_out, if1.b_out}];
  assign if2.y_in = gateTable[2][{if2.a_out, if2.b_out}];

  assign abObs[0]   = {if0.a_out, if0.b_out};
  assign abObs[1]   = {if1.a_out, if1.b_out};
  assign abObs[2]   = {if2.a_out, if2.b_out};
  assign busyObs[0] = if0.busy;
  assign busyObs[1] = if1.busy;
  assign busyObs[2] = if2.busy;
  assign doneObs[0] = if0.done;
  assign doneObs[1] = if1.done;
  assign doneObs[2] = if2.done;
  assign passObs[0] = if0.pass;
  assign passObs[1] = if1.pass;
  assign passObs[2] = if2.pass;
  assign errObs[0]  = if0.err_count;
  assign errObs[1]  = if1.err_count;
  assign errObs[2]  = if2.err_count;
  assign failObs[0] = if0.fail_vec;
  assign failObs[1] = if1.fail_vec;
  assign failObs[2] = if2.fail_vec;

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Pulse start on one instance; returns at the falling edge of cycle 0 of the run.
  task automatic applyStimulus(input int d);
    @(negedge clock);
    startSig[d] = 1'b1;
    @(negedge clock);
    startSig[d] = 1'b0;
  endtask

  // Follows a run from cycle firstK to done, then checks the results.
  task automatic checkRun(input int d, input int s, input int r, input logic [3:0] truth,
                          input logic [3:0] tbl, input int firstK, input bit randStarts,
                          input bit holdAtEnd, input string tag);
    int n;
    int mism;
    int abBad;
    int busyBad;
    int doneBad;
    logic [7:0] expErr;
    logic [3:0] expFail;
    logic       expPass;
    n       = r * 4 * (s + 1);
    mism    = $countones(truth ^ tbl) * r;
    expErr  = (mism > 255) ? 8'd255 : 8'(mism);
    expFail = truth ^ tbl;
    expPass = (mism == 0);
    abBad   = 0;
    busyBad = 0;
    doneBad = 0;
    for (int k = firstK; k < n; k++) begin
      if (abObs[d] !== 2'((k / (s + 1)) % 4)) abBad++;
      if (busyObs[d] !== 1'b1) busyBad++;
      if (doneObs[d] !== 1'b0) doneBad++;
      if (k == n - 1) startSig[d] = holdAtEnd;
      else if (randStarts) startSig[d] = 1'($urandom_range(0, 1));
      else startSig[d] = 1'b0;
      @(negedge clock);
    end
    checkOutput({tag, "/abSequence"}, abBad, 0);
    checkOutput({tag, "/busyDuringRun"}, busyBad, 0);
    checkOutput({tag, "/earlyDone"}, doneBad, 0);
    checkOutput({tag, "/doneAtEnd"}, doneObs[d], 1);
    checkOutput({tag, "/busyAtEnd"}, busyObs[d], 0);
    checkOutput({tag, "/abAtEnd"}, abObs[d], 0);
    checkOutput({tag, "/pass"}, passObs[d], expPass);
    checkOutput({tag, "/errCount"}, errObs[d], expErr);
    checkOutput({tag, "/failVec"}, failObs[d], expFail);
    if (!holdAtEnd) begin
      @(negedge clock);
      checkOutput({tag, "/doneOneCycle"}, doneObs[d], 0);
      checkOutput({tag, "/errHeld"}, errObs[d], expErr);
      checkOutput({tag, "/failHeld"}, failObs[d], expFail);
      checkOutput({tag, "/passHeld"}, passObs[d], expPass);
    end
  endtask

  initial begin
    int doneSeen;
    int busySeen;
    logic [3:0] tbl;

    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      startSig[d]  = 1'b0;
      gateTable[d] = 4'b0000;
    end

    // Reset state of every instance.
    repeat (3) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset/ab", abObs[d], 0);
      checkOutput("reset/busy", busyObs[d], 0);
      checkOutput("reset/done", doneObs[d], 0);
      checkOutput("reset/pass", passObs[d], 0);
      checkOutput("reset/err", errObs[d], 0);
      checkOutput("reset/fail", failObs[d], 0);
    end
    reset = 1'b0;

    // Asynchronous reset in the middle of combination 10 with an OR gate attached.
    gateTable[0] = 4'b1110;
    applyStimulus(0);
    repeat (6) @(negedge clock);
    checkOutput("midRun/ab", abObs[0], 2'b10);
    checkOutput("midRun/liveErr", errObs[0], 1);
    checkOutput("midRun/liveFail", failObs[0], 4'b0010);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRst/ab", abObs[0], 0);
    checkOutput("asyncRst/busy", busyObs[0], 0);
    checkOutput("asyncRst/err", errObs[0], 0);
    checkOutput("asyncRst/fail", failObs[0], 0);
    checkOutput("asyncRst/pass", passObs[0], 0);
    @(negedge clock);
    reset = 1'b0;
    doneSeen = 0;
    busySeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (doneObs[0] === 1'b1) doneSeen++;
      if (busyObs[0] === 1'b1) busySeen++;
    end
    checkOutput("asyncRst/noDone", doneSeen, 0);
    checkOutput("asyncRst/staysIdle", busySeen, 0);

    // Ideal AND gate after the aborted run.
    gateTable[0] = 4'b1000;
    applyStimulus(0);
    checkRun(0, 2, 1, 4'b1000, 4'b1000, 0, 1'b0, 1'b0, "andGate");

    // OR gate against the AND table, with stray start pulses while busy.
    gateTable[0] = 4'b1110;
    applyStimulus(0);
    checkRun(0, 2, 1, 4'b1000, 4'b1110, 0, 1'b1, 1'b0, "orGate");

    // Y tied high for 100 rounds: error count saturates.
    gateTable[1] = 4'b1111;
    applyStimulus(1);
    checkRun(1, 2, 100, 4'b1000, 4'b1111, 0, 1'b1, 1'b0, "tiedHigh");

    // Ideal XOR gate on the XOR instance.
    gateTable[2] = 4'b0110;
    applyStimulus(2);
    checkRun(2, 1, 2, 4'b0110, 4'b0110, 0, 1'b0, 1'b0, "xorGate");

    // Start held through done: a second run begins right away with results cleared.
    tbl = 4'($urandom_range(1, 15));
    if (tbl == 4'b1000) tbl = 4'b0001;
    gateTable[0] = tbl;
    applyStimulus(0);
    checkRun(0, 2, 1, 4'b1000, tbl, 0, 1'b1, 1'b1, "heldStart1");
    @(negedge clock);
    checkOutput("heldStart/busy", busyObs[0], 1);
    checkOutput("heldStart/done", doneObs[0], 0);
    checkOutput("heldStart/ab", abObs[0], 0);
    checkOutput("heldStart/errCleared", errObs[0], 0);
    checkOutput("heldStart/failCleared", failObs[0], 0);
    checkOutput("heldStart/passCleared", passObs[0], 0);
    startSig[0] = 1'b0;
    @(negedge clock);
    checkRun(0, 2, 1, 4'b1000, tbl, 1, 1'b1, 1'b0, "heldStart2");

    // Random gate tables against both short-run instances.
    for (int i = 0; i < 4; i++) begin
      tbl = 4'($urandom_range(0, 15));
      gateTable[0] = tbl;
      applyStimulus(0);
      checkRun(0, 2, 1, 4'b1000, tbl, 0, 1'b1, 1'b0, "randAnd");
      tbl = 4'($urandom_range(0, 15));
      gateTable[2] = tbl;
      applyStimulus(2);
      checkRun(2, 1, 2, 4'b0110, tbl, 0, 1'b1, 1'b0, "randXor");
    end

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
